// File: rtl/phy_slot_sequencer.sv
// Frame/slot scheduler for one phy_channel: sync, guard gap, four virtual-channel slots, complete strobe.
// Optional SLOT_SKIP_EN: slots whose shadow data_len is zero take no cycles at all.
module phy_slot_sequencer #(
  parameter int GUARD_TICKS = 2,
  parameter int TICK_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_trig,
  input  logic              i_abort,
  input  logic              i_cfg_wr,
  input  logic [2:0]        i_cfg_addr,
  input  logic [TICK_W-1:0] i_cfg_data,
  output logic              o_sync,
  output logic              o_slot_sync,
  output logic [1:0]        o_wr_vchn,
  output logic [7:0]        o_data_len,
  output logic [3:0]        o_ch_mask,
  output logic              o_complite,
  output logic              o_busy,
  output logic              o_overrun
);

  typedef enum logic [2:0] {IDLE, SYNC, GUARD, SLOT, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        vch_q, vch_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              overrun_q, overrun_d;

  logic [TICK_W-1:0] ticks_q [4];
  logic [TICK_W-1:0] ticks_sh_q [4];
  logic [7:0]        len_q [4];
  logic [7:0]        len_sh_q [4];

  logic [3:0]        skip;
  logic [2:0]        searchFrom;
  logic              nxtFound;
  logic [1:0]        nxtIdx;
  logic [TICK_W-1:0] tickLoad;

  // Live regs take host writes any time; shadows freeze them for the frame on entry to SYNC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ticks_q[i]    <= '0;
        ticks_sh_q[i] <= '0;
        len_q[i]      <= '0;
        len_sh_q[i]   <= '0;
      end
    end else begin
      if (i_cfg_wr) begin
        if (i_cfg_addr[2]) len_q[i_cfg_addr[1:0]]   <= i_cfg_data[7:0];
        else               ticks_q[i_cfg_addr[1:0]] <= i_cfg_data;
      end
      if (state_d == SYNC) begin
        for (int i = 0; i < 4; i++) begin
          ticks_sh_q[i] <= ticks_q[i];
          len_sh_q[i]   <= len_q[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef SLOT_SKIP_EN
      skip[i] = (len_sh_q[i] == 8'd0);
`else
      skip[i] = 1'b0;
`endif
    end
  end

  // Lowest non-skipped slot at or after searchFrom; none found means the frame is finished.
  always_comb begin
    searchFrom = (state_q == SLOT) ? ({1'b0, vch_q} + 3'd1) : 3'd0;
    nxtFound   = 1'b0;
    nxtIdx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= searchFrom) && !skip[i]) begin
        nxtFound = 1'b1;
        nxtIdx   = 2'(i);
      end
    end
    tickLoad = (ticks_sh_q[nxtIdx] == '0) ? '0 : ticks_sh_q[nxtIdx] - TICK_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    vch_d     = vch_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    overrun_d = i_trig && (state_q != IDLE) && !i_abort;
    case (state_q)
      IDLE: if (i_trig) state_d = SYNC;
      SYNC: begin
        state_d = GUARD;
        cnt_d   = TICK_W'(GUARD_TICKS - 1);
      end
      GUARD, SLOT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TICK_W'(1);
        end else if (nxtFound) begin
          state_d = SLOT;
          vch_d   = nxtIdx;
          cnt_d   = tickLoad;
          first_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) begin
      state_d = IDLE;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vch_q     <= 2'd0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vch_q     <= vch_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    o_sync      = (state_q == SYNC);
    o_slot_sync = (state_q == SLOT) && first_q;
    o_complite  = (state_q == DONE);
    o_busy      = (state_q != IDLE);
    o_overrun   = overrun_q;
    o_wr_vchn   = (state_q == SLOT) ? vch_q : 2'd0;
    o_data_len  = (state_q == SLOT) ? len_sh_q[vch_q] : 8'd0;
    o_ch_mask   = (state_q == SLOT) ? (4'b0001 << vch_q) : 4'b0000;
  end

endmodule

// File: tb/tb_phy_slot_sequencer.sv
// Self-checking bench for phy_slot_sequencer: directed scenarios plus randomized frames
// compared cycle by cycle against a frame-level reference model.
module tb_phy_slot_sequencer;

  localparam int G  = 2;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_trig, i_abort, i_cfg_wr;
  logic [2:0]    i_cfg_addr;
  logic [TW-1:0] i_cfg_data;
  logic          o_sync, o_slot_sync, o_complite, o_busy, o_overrun;
  logic [1:0]    o_wr_vchn;
  logic [7:0]    o_data_len;
  logic [3:0]    o_ch_mask;

  phy_slot_sequencer #(.GUARD_TICKS(G), .TICK_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .i_trig(i_trig), .i_abort(i_abort),
    .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_sync(o_sync), .o_slot_sync(o_slot_sync), .o_wr_vchn(o_wr_vchn),
    .o_data_len(o_data_len), .o_ch_mask(o_ch_mask), .o_complite(o_complite),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sync;
    logic       slotSync;
    logic       complite;
    logic       busy;
    logic       overrun;
    logic [1:0] vchn;
    logic [7:0] len;
    logic [3:0] mask;
  } obs_t;

  obs_t obs_q[$];
  obs_t exp_q[$];
  int   liveTicks[4], liveLen[4], shTicks[4], shLen[4];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   evAddr, evData;

  function automatic obs_t sampleNow();
    obs_t o;
    o.sync = o_sync; o.slotSync = o_slot_sync; o.complite = o_complite;
    o.busy = o_busy; o.overrun = o_overrun; o.vchn = o_wr_vchn;
    o.len = o_data_len; o.mask = o_ch_mask;
    return o;
  endfunction

  function automatic bit slotSkipped(int v);
`ifdef SLOT_SKIP_EN
    return shLen[v] == 0;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles from o_sync through o_complite, computed from the shadow snapshot.
  function automatic int frameLen();
    int n = 2 + G;
    for (int v = 0; v < 4; v++)
      if (!slotSkipped(v)) n += (shTicks[v] == 0) ? 1 : shTicks[v];
    return n;
  endfunction

  function automatic void buildExpected(int nCyc, int evCycle, int evKind);
    obs_t e;
    exp_q.delete();
    e = '0; e.sync = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
    e = '0; e.busy = 1'b1;
    for (int g = 0; g < G; g++) exp_q.push_back(e);
    for (int v = 0; v < 4; v++) begin
      if (!slotSkipped(v)) begin
        for (int c = 0; c < ((shTicks[v] == 0) ? 1 : shTicks[v]); c++) begin
          e = '0; e.busy = 1'b1; e.slotSync = (c == 0);
          e.vchn = 2'(v); e.len = 8'(shLen[v]); e.mask = 4'(1 << v);
          exp_q.push_back(e);
        end
      end
    end
    e = '0; e.complite = 1'b1; e.busy = 1'b1; exp_q.push_back(e);
    while (exp_q.size() < nCyc) exp_q.push_back('0);
    if (evKind == 2)
      for (int i = evCycle; i < nCyc; i++) exp_q[i] = '0;
    if (evKind == 1 && exp_q[evCycle-1].busy) begin
      e = exp_q[evCycle]; e.overrun = 1'b1; exp_q[evCycle] = e;
    end
  endfunction

  task automatic cfgWrite(input int addr, input int data);
    i_cfg_wr = 1'b1; i_cfg_addr = 3'(addr); i_cfg_data = TW'(data);
    @(posedge clk); #1;
    i_cfg_wr = 1'b0;
    if (addr >= 4) liveLen[addr-4] = data & 255;
    else           liveTicks[addr] = data;
  endtask

  task automatic setCfg(input int t0, t1, t2, t3, l0, l1, l2, l3);
    cfgWrite(0, t0); cfgWrite(1, t1); cfgWrite(2, t2); cfgWrite(3, t3);
    cfgWrite(4, l0); cfgWrite(5, l1); cfgWrite(6, l2); cfgWrite(7, l3);
  endtask

  // Trigger at step 0; evKind 1=trig, 2=abort, 3=cfg write (evAddr/evData) lands at step evCycle.
  task automatic runFrame(input int extra, input int evCycle, input int evKind);
    int nCyc;
    shTicks = liveTicks;
    shLen   = liveLen;
    nCyc    = frameLen() + extra;
    buildExpected(nCyc, evCycle, evKind);
    obs_q.delete();
    for (int k = 0; k < nCyc; k++) begin
      i_trig  = (k == 0) || (evKind == 1 && k == evCycle);
      i_abort = (evKind == 2 && k == evCycle);
      if (evKind == 3 && k == evCycle) begin
        i_cfg_wr = 1'b1; i_cfg_addr = 3'(evAddr); i_cfg_data = TW'(evData);
        if (evAddr >= 4) liveLen[evAddr-4] = evData & 255;
        else             liveTicks[evAddr] = evData;
      end
      @(posedge clk); #1;
      i_trig = 1'b0; i_abort = 1'b0; i_cfg_wr = 1'b0;
      obs_q.push_back(sampleNow());
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0; i_trig = 1'b0; i_abort = 1'b0; i_cfg_wr = 1'b0;
    i_cfg_addr = '0; i_cfg_data = '0;
    repeat (2) @(posedge clk); #1;
    o = sampleNow(); testsRun++;
    if (o !== '0) begin testsFailed++; $display("[TB] FAIL reset_idle actual=%h expected=0", o); end
    rst_n = 1'b1;
    setCfg(3, 3, 3, 3, 9, 9, 9, 9);
    i_trig = 1'b1; @(posedge clk); #1; i_trig = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    o = sampleNow(); testsRun++;
    if (o !== '0) begin testsFailed++; $display("[TB] FAIL reset_midframe actual=%h expected=0", o); end
    liveTicks = '{0, 0, 0, 0}; liveLen = '{0, 0, 0, 0};
    @(posedge clk); #1; rst_n = 1'b1;
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL reset_cfg cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_basic();
    setCfg(4, 4, 4, 4, 8, 8, 8, 8);
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL basic cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
    testsRun++;
    if (obs_q[3].slotSync !== 1'b1 || obs_q[19].complite !== 1'b1) begin testsFailed++;
      $display("[TB] FAIL basic_latency actual=%b%b expected=11", obs_q[3].slotSync, obs_q[19].complite); end
  endtask

  task automatic test_ticks();
    setCfg(1, 0, 3, 2, 8, 8, 8, 8);
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL ticks cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    setCfg(4, 4, 4, 4, 8, 8, 8, 8);
    runFrame(2, 1 + G + 8 + 1, 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL overrun cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    runFrame(2, 1 + G + 4 + 1, 2);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL abort cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL abort_restart cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_shadow();
    evAddr = 4; evData = 5;
    runFrame(2, 2, 3);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL shadow_cur cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL shadow_next cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_skip();
    int pulses = 0;
    int want;
`ifdef SLOT_SKIP_EN
    want = 2;
`else
    want = 4;
`endif
    setCfg(2, 2, 2, 2, 8, 0, 0, 8);
    runFrame(2, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      testsRun++;
      if (obs_q[i].slotSync === 1'b1) pulses++;
      if (obs_q[i] !== exp_q[i]) begin testsFailed++;
        $display("[TB] FAIL skip cyc=%0d actual=%h expected=%h", i, obs_q[i], exp_q[i]); end
    end
    testsRun++;
    if (pulses != want) begin testsFailed++;
      $display("[TB] FAIL skip_count actual=%0d expected=%0d", pulses, want); end
  endtask

  task automatic test_random();
    int kind, ev, fl;
    for (int n = 0; n < 24; n++) begin
      setCfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
      shTicks = liveTicks; shLen = liveLen;
      fl     = frameLen();
      kind   = $urandom_range(0, 3);
      ev     = $urandom_range(1, fl - 1);
      evAddr = $urandom_range(0, 7);
      evData = (evAddr >= 4) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      runFrame(2, ev, kind);
      for (int i = 0; i < obs_q.size(); i++) begin
        testsRun++;
        if (obs_q[i] !== exp_q[i]) begin testsFailed++;
          $display("[TB] FAIL random it=%0d kind=%0d cyc=%0d actual=%h expected=%h",
                   n, kind, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ticks();
    test_overrun();
    test_abort();
    test_shadow();
    test_skip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
